// File: rtl/imm_extend_pipe_pkg.sv
// imm_extend_pipe_pkg: immediate type codes and default width shared by the immediate pipeline
package imm_extend_pipe_pkg;
  typedef enum logic [2:0] {
    RTYPE = 3'd0,
    ITYPE = 3'd1,
    STYPE = 3'd2,
    BTYPE = 3'd3,
    UTYPE = 3'd4,
    JTYPE = 3'd5,
    ZTYPE = 3'd6,
    UNDEF = 3'd7
  } imm_type_e;
  localparam int XLEN_DEFAULT = 32;
endpackage

// File: rtl/imm_extend_core.sv
// imm_extend_core: combinational RV32I/RV64I immediate decode and sign-extend to XLEN
// IMM_CSR_ZIMM_EN: when defined, ZTYPE decodes the CSR zimm field instead of flagging illegal
module imm_extend_core import imm_extend_pipe_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     inst,
  input  logic [2:0]      imm_type,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);
  logic [31:0] raw;
  logic        unused_opcode;
  assign unused_opcode = ^inst[6:0];
  always_comb begin
    raw     = '0;
    illegal = 1'b0;
    case (imm_type)
      RTYPE:   raw = '0;
      ITYPE:   raw = {{20{inst[31]}}, inst[31:20]};
      STYPE:   raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      BTYPE:   raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      UTYPE:   raw = {inst[31:12], 12'b0};
      JTYPE:   raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
`ifdef IMM_CSR_ZIMM_EN
      ZTYPE:   raw = {27'b0, inst[19:15]};
`endif
      default: illegal = 1'b1;
    endcase
  end
  // RV64 extends every type (including U) from bit 31; zimm has bit 31 clear so stays zero-extended
  assign imm = XLEN'(signed'(raw));
endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: ID/EX immediate segment, decode then LATENCY stage registers with bubble/flush
// IMM_CSR_ZIMM_EN: forwarded to imm_extend_core to enable the CSR zimm decode
module imm_extend_pipe import imm_extend_pipe_pkg::*; #(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [31:0]     inst,
  input  logic [2:0]      imm_type,
  input  logic            bubble,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] imm,
  output logic            imm_illegal
);
  logic [XLEN-1:0]    dec_imm, imm_d;
  logic               dec_ill, ill_d;
  logic [LATENCY-1:0] valid_q, ill_q;
  logic [XLEN-1:0]    imm_q [LATENCY];
  imm_extend_core #(.XLEN(XLEN)) u_core (
    .inst     (inst),
    .imm_type (imm_type),
    .imm      (dec_imm),
    .illegal  (dec_ill)
  );
  // empty slots enter as all-zero so nothing stale trails a bubble
  assign imm_d = in_valid ? dec_imm : '0;
  assign ill_d = in_valid & dec_ill;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= '0;
      ill_q   <= '0;
      for (int s = 0; s < LATENCY; s++) imm_q[s] <= '0;
    end else if (!bubble) begin
      valid_q[0] <= in_valid;
      ill_q[0]   <= ill_d;
      imm_q[0]   <= imm_d;
      for (int s = 1; s < LATENCY; s++) begin
        valid_q[s] <= valid_q[s-1];
        ill_q[s]   <= ill_q[s-1];
        imm_q[s]   <= imm_q[s-1];
      end
    end
  end
  assign out_valid   = valid_q[LATENCY-1];
  assign imm         = imm_q[LATENCY-1];
  assign imm_illegal = valid_q[LATENCY-1] & ill_q[LATENCY-1];
endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Parametrised immediate generator for the RV32I/RV64I core, sitting between ID and EX as the immediate pipeline segment. Decodes the immediate combinationally from the instruction word and immediate type. Sign-extends to XLEN. Carries the result through LATENCY registered stages with valid, bubble (hold) and flush (kill) semantics that match the other ID/EX segment registers.

Parameters:
XLEN, 32, output immediate width; legal values 32 or 64.
LATENCY, 1, number of register stages from input to output; legal range 1..3.

Ports:
clk  in  1  core clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  inst/imm_type are a real instruction this cycle.
inst  in  32  full instruction word.
imm_type  in  3  immediate type code (Parameters.v encoding).
bubble  in  1  stall: every stage holds its contents.
flush  in  1  kill: every stage is cleared.
out_valid  out  1  imm/imm_illegal belong to a real instruction.
imm  out  XLEN  extended immediate.
imm_illegal  out  1  imm_type was an undefined code; qualified by out_valid.

Behaviour:
- Type codes: RTYPE=3'd0, ITYPE=3'd1, STYPE=3'd2, BTYPE=3'd3, UTYPE=3'd4, JTYPE=3'd5, ZTYPE=3'd6; 3'd7 is undefined.
- Decode (32-bit core value, then sign-extend bit 31 to XLEN):
  - I: inst[31:20].
  - S: inst[31:25],inst[11:7].
  - B: inst[31],inst[7],inst[30:25],inst[11:8],0.
  - U: inst[31:12],12'b0.
  - J: inst[31],inst[19:12],inst[20],inst[30:21],0.
  - R: 0.
- For XLEN=64, U-type is also sign-extended from bit 31 (RV64 LUI/AUIPC semantics).
- Undefined code: imm=0, imm_illegal=1.
- Stage register update, in priority order:
  1. rst: valid=0, imm=0, illegal=0.
  2. flush: same clear as rst. flush beats bubble.
  3. bubble: all stages hold.
  4. otherwise: shift one stage. Stage 0 loads the decode result.
- in_valid=0 loads valid=0, imm=0, illegal=0 into stage 0, so no stale data follows a bubble slot.
- Latency: an input accepted in cycle N appears at the outputs after LATENCY rising edges, unless it is flushed or held.
- Outputs come directly from the last stage (no combinational path from inputs). imm_illegal is forced 0 whenever out_valid=0.
- Reset mid-operation clears every stage on that edge. Outputs read 0 on the following cycle.
- bubble asserted for K cycles holds the output constant for K cycles. Input during a bubble is dropped; upstream must hold it.

Optional Feature:
IMM_CSR_ZIMM_EN
- Defined: ZTYPE decodes to zero-extended inst[19:15] (CSRRWI/CSRRSI/CSRRCI), imm_illegal=0.
- Undefined: ZTYPE is treated as an undefined code: imm=0, imm_illegal=1.

Decomposition:
- Type-code constants (RTYPE..ZTYPE) and the XLEN default stay in the shared Parameters.v header used by the whole core.
- One sub-module, imm_extend_core: purely combinational decode and extend (inst, imm_type -> imm, illegal), parametrised by XLEN.
- imm_extend_pipe instantiates imm_extend_core and generates LATENCY stage registers.

Test Plan:
1. ITYPE, inst=0xFFF00093, in_valid=1, LATENCY=1 -> next cycle out_valid=1, imm=0xFFFFFFFF. With XLEN=64, imm=0xFFFFFFFFFFFFFFFF.
2. BTYPE, inst=0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC. JTYPE, inst=0x0080006F (jal x0,+8) -> imm=0x00000008.
3. UTYPE, inst=0x800000B7 -> XLEN=32: imm=0x80000000. XLEN=64: imm=0xFFFFFFFF80000000.
4. LATENCY=2, stream of 3 ITYPE values, bubble high for 2 cycles mid-stream -> outputs frozen for 2 cycles, then the sequence resumes with no value lost or duplicated.
5. flush and bubble high in the same cycle -> next cycle out_valid=0, imm=0. rst pulsed with all stages full -> all stages clear; out_valid=0 the next cycle.
6. imm_type=3'd6, inst[19:15]=5'b10101 -> with IMM_CSR_ZIMM_EN: imm=0x15, imm_illegal=0. Without it: imm=0, imm_illegal=1. imm_type=3'd7 -> imm_illegal=1 in both builds.
